// File: rtl/bus_arbiter_pkg.sv
// Shared bus constants, arbiter state record and small helpers used by the
// bus arbiter and its round-robin picker.
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH      = 4;
  localparam int BUS_MASTER_INDEX_W = 2;
  localparam int BUS_ADDR_W         = 32;
  localparam int BUS_DATA_W         = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic READ    = 1'b1;
  localparam logic WRITE   = 1'b0;

  typedef logic [BUS_MASTER_INDEX_W-1:0] midx_t;
  typedef logic [BUS_MASTER_CH-1:0]      mmask_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    arb_state_e state;
    midx_t      owner;
    midx_t      last;
  } arb_ctx_t;

  function automatic mmask_t idx2onehot(input midx_t i);
    mmask_t oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin search: first set bit of req at start, start+1, ...
// wrapping modulo the master count.
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  mmask_t req,
  input  midx_t  start,
  output logic   found,
  output midx_t  win
);

  // Walk offsets from the far end so the closest requester to start wins last.
  always_comb begin : search
    midx_t idx;
    idx   = '0;
    found = 1'b0;
    win   = start;
    for (int i = BUS_MASTER_CH-1; i >= 0; i--) begin
      idx = start + midx_t'(i);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with hold-time preemption at
// transaction boundaries, plus the master-to-shared-bus multiplexer.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [BUS_MASTER_CH-1:0]             m_req,
  input  logic [BUS_MASTER_CH*BUS_ADDR_W-1:0]  m_addr,
  input  logic [BUS_MASTER_CH-1:0]             m_as,
  input  logic [BUS_MASTER_CH-1:0]             m_rw,
  input  logic [BUS_MASTER_CH*BUS_DATA_W-1:0]  m_wr_data,
  output logic [BUS_MASTER_CH-1:0]             m_grnt,
  output logic [BUS_ADDR_W-1:0]                s_addr,
  output logic                                 s_as,
  output logic                                 s_rw,
  output logic [BUS_DATA_W-1:0]                s_wr_data
);

  localparam int HOLD_W = ($clog2(MAX_HOLD + 1) > 5) ? $clog2(MAX_HOLD + 1) : 5;

  arb_ctx_t            cur, nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  mmask_t              grnt_nxt;
  mmask_t              own_oh, others, pick_req;
  midx_t               pick_start, pick_win;
  logic                pick_found, own_req, own_as, hold_sat, at_limit;

  assign own_oh   = idx2onehot(cur.owner);
  assign others   = m_req & ~own_oh;
  assign own_req  = |(m_req & own_oh);
  assign own_as   = |(m_as & own_oh);
  assign hold_sat = (hold_cnt == HOLD_W'(MAX_HOLD));
  assign at_limit = (MAX_HOLD != 0) && hold_sat;

  // While busy the owner is masked out, so a release or a preemption both
  // search the other masters starting just past the owner.
  assign pick_req   = (cur.state == ARB_BUSY) ? others : m_req;
  assign pick_start = ((cur.state == ARB_BUSY) ? cur.owner : cur.last) + midx_t'(1);

  bus_rr_pick u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .win   (pick_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '{state: ARB_IDLE, owner: '0, last: midx_t'(BUS_MASTER_CH-1)};
      hold_cnt <= '0;
      m_grnt   <= '0;
    end else begin
      cur      <= nxt;
      hold_cnt <= hold_nxt;
      m_grnt   <= grnt_nxt;
    end
  end

  always_comb begin
    nxt      = cur;
    hold_nxt = hold_cnt;
    case (cur.state)
      ARB_IDLE: begin
        hold_nxt = '0;
        if (pick_found) begin
          nxt.state = ARB_BUSY;
          nxt.owner = pick_win;
          nxt.last  = pick_win;
        end
      end
      ARB_BUSY: begin
        // Preemption only at a cycle with no transaction, and only if someone
        // is still there to take the bus.
        if (!own_req || (at_limit && !own_as && pick_found)) begin
          hold_nxt = '0;
          if (pick_found) begin
            nxt.owner = pick_win;
            nxt.last  = pick_win;
          end else begin
            nxt.state = ARB_IDLE;
          end
        end else if (|others) begin
          hold_nxt = hold_sat ? hold_cnt : hold_cnt + HOLD_W'(1);
        end else begin
          hold_nxt = '0;
        end
      end
      default: nxt = cur;
    endcase
    grnt_nxt = (nxt.state == ARB_BUSY) ? idx2onehot(nxt.owner) : '0;
  end

  always_comb begin
    s_addr    = '0;
    s_as      = DISABLE;
    s_rw      = READ;
    s_wr_data = '0;
    if (cur.state == ARB_BUSY) begin
      s_addr    = m_addr[int'(cur.owner)*BUS_ADDR_W +: BUS_ADDR_W];
      s_as      = m_as[cur.owner];
      s_rw      = m_rw[cur.owner];
      s_wr_data = m_wr_data[int'(cur.owner)*BUS_DATA_W +: BUS_DATA_W];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance with MAX_HOLD=4 and one with
// preemption disabled, both driven from the same master stimulus.
module tb_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   m_req = '0;
  logic [127:0] m_addr;
  logic [3:0]   m_as = '0;
  logic [3:0]   m_rw = '1;
  logic [127:0] m_wr_data;

  logic [3:0]   grnt_a, grnt_b;
  logic [31:0]  s_addr_a, s_addr_b, s_wr_data_a, s_wr_data_b;
  logic         s_as_a, s_as_b, s_rw_a, s_rw_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_as(m_as),
    .m_rw(m_rw), .m_wr_data(m_wr_data), .m_grnt(grnt_a), .s_addr(s_addr_a),
    .s_as(s_as_a), .s_rw(s_rw_a), .s_wr_data(s_wr_data_a)
  );

  bus_arbiter #(.MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_as(m_as),
    .m_rw(m_rw), .m_wr_data(m_wr_data), .m_grnt(grnt_b), .s_addr(s_addr_b),
    .s_as(s_as_b), .s_rw(s_rw_b), .s_wr_data(s_wr_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reset held across one rising edge, released on a falling edge.
  task automatic do_reset();
    m_req = '0;
    m_as  = '0;
    m_rw  = '1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] cur, nxt;
    m_addr    = {32'h8000_3333, 32'h4000_2222, 32'h2000_1111, 32'h6000_0000};
    m_wr_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    // Reset state
    step();
    chk("rst_grnt", grnt_a, 4'b0000);
    chk("rst_addr", s_addr_a, 32'h0);
    chk("rst_as", s_as_a, 1'b0);
    chk("rst_rw", s_rw_a, 1'b1);
    chk("rst_wdata", s_wr_data_a, 32'h0);

    // Single request: one-cycle grant latency, bus follows the grant
    rst_n = 1'b1;
    m_req = 4'b0100;
    chk("lat_pre", grnt_a, 4'b0000);
    step();
    chk("lat_grnt", grnt_a, 4'b0100);
    chk("lat_addr", s_addr_a, 32'h4000_2222);
    chk("lat_wdata", s_wr_data_a, 32'hD000_0002);
    m_as = 4'b0100;
    m_rw = 4'b1011;
    #1;
    chk("mux_as", s_as_a, 1'b1);
    chk("mux_rw", s_rw_a, 1'b0);
    // Asynchronous reset in the middle of a granted transaction
    #1 rst_n = 1'b0;
    #1;
    chk("arst_grnt", grnt_a, 4'b0000);
    chk("arst_as", s_as_a, 1'b0);
    chk("arst_addr", s_addr_a, 32'h0);
    step();
    m_as = '0; m_rw = '1; m_req = '0;
    rst_n = 1'b1;

    // All request, each owner releases after three cycles of ownership
    m_req = 4'b1111;
    step();
    cur = 4'b0001;
    chk("rr_first", grnt_b, cur);
    for (int k = 0; k < 4; k++) begin
      repeat (2) begin
        step();
        chk("rr_hold", grnt_b, cur);
      end
      m_req = ~cur;
      nxt = {cur[2:0], cur[3]};
      step();
      chk("rr_hand", grnt_b, nxt);
      m_req = 4'b1111;
      cur = nxt;
    end

    // Preemption waits for a cycle without address strobe
    do_reset();
    m_req = 4'b0010;
    step();
    chk("pre_own", grnt_a, 4'b0010);
    m_req = 4'b1010;
    for (int k = 1; k <= 6; k++) begin
      m_as = (k % 2 == 1) ? 4'b0010 : 4'b0000;
      step();
      chk("preempt", grnt_a, (k < 6) ? 4'b0010 : 4'b1000);
    end
    m_as = '0;

    // Preemption disabled: owner keeps the bus indefinitely
    do_reset();
    m_req = 4'b0001;
    step();
    chk("nopre_own", grnt_b, 4'b0001);
    m_req = 4'b0101;
    repeat (100) begin
      step();
      chk("nopre_hold", grnt_b, 4'b0001);
    end

    // Release search wraps past index 3; release with nobody waiting idles
    do_reset();
    m_req = 4'b0100;
    step();
    chk("wrap_own", grnt_b, 4'b0100);
    m_req = 4'b0011;
    step();
    chk("wrap_next", grnt_b, 4'b0001);
    m_req = 4'b0100;
    step();
    chk("wrap_back", grnt_b, 4'b0100);
    m_req = 4'b0000;
    step();
    chk("idle_grnt", grnt_b, 4'b0000);
    chk("idle_addr", s_addr_b, 32'h0);
    chk("idle_as", s_as_b, 1'b0);

    // Slave select bits valid in the same cycle as the grant
    do_reset();
    m_req = 4'b0001;
    chk("sel_pre_grnt", grnt_b, 4'b0000);
    chk("sel_pre_addr", s_addr_b, 32'h0);
    step();
    chk("sel_grnt", grnt_b, 4'b0001);
    chk("sel_addr", s_addr_b, 32'h6000_0000);
    chk("sel_slave", {29'h0, s_addr_b[31:29]}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
